// File: rtl/led_blink_scheduler_pkg.sv
// Shared types and default sizing for the LED blink scheduler.
package led_blink_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  localparam int DEF_TICK_DIV = 1000000;
  localparam int DEF_CNT_W    = 8;
  localparam int DEF_REP_W    = 4;

endpackage

// File: rtl/led_blink_scheduler_tick_gen.sv
// Blink-tick prescaler: one-cycle tick every TICK_DIV enabled cycles, restartable via clr.
module led_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int TW = $clog2(TICK_DIV);

  logic [TW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == TW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + TW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_blink_scheduler.sv
// Priority-arbitrated LED blink sequencer (IDLE/ON/OFF), all outputs registered.
// Optional preemption by a higher-priority requester: define LED_BLINK_PREEMPT_EN.
module led_blink_scheduler
  import led_blink_scheduler_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int NREQ     = 3,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int REP_W    = DEF_REP_W,
  localparam int OWN_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] on_ticks,
  input  logic [NREQ*CNT_W-1:0] off_ticks,
  input  logic [NREQ*REP_W-1:0] rep,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic                  done,
  output logic [OWN_W-1:0]      owner,
  output logic                  LED
);

  state_e             state_q, state_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               led_q, led_d;
  logic               armed_q, armed_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   on_q, on_d, off_q, off_d, rem_q, rem_d;
  logic [REP_W-1:0]   rep_q, rep_d, blink_q, blink_d;

  logic               req_any, preempt, grant, tick;
  logic [OWN_W-1:0]   req_idx;
  logic [CNT_W-1:0]   g_on, g_off, start_on, start_off;
  logic [REP_W-1:0]   g_rep, rep_eff;
  logic               start_blink, blink_end;

  // Lowest set index wins; scanning downward lets the last hit be the smallest.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    req_any = 1'b0;
    req_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        req_any = 1'b1;
        req_idx = OWN_W'(i);
      end
    end
  end

`ifdef LED_BLINK_PREEMPT_EN
  assign preempt = busy_q && req_any && (req_idx < owner_q);
`else
  assign preempt = 1'b0;
`endif

  // armed_q holds off grants for the first edge after reset so IDLE always lasts a cycle.
  assign grant   = armed_q && req_any && ((state_q == ST_IDLE) || preempt);
  assign g_on    = on_ticks[int'(req_idx) * CNT_W +: CNT_W];
  assign g_off   = off_ticks[int'(req_idx) * CNT_W +: CNT_W];
  assign g_rep   = rep[int'(req_idx) * REP_W +: REP_W];
  assign rep_eff = (rep_q == '0) ? REP_W'(1) : rep_q;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (grant),
    .en   (busy_q),
    .tick (tick)
  );

  always_comb begin
    state_d     = state_q;
    ack_d       = '0;
    done_d      = 1'b0;
    armed_d     = 1'b1;
    owner_d     = owner_q;
    on_d        = on_q;
    off_d       = off_q;
    rep_d       = rep_q;
    rem_d       = rem_q;
    blink_d     = blink_q;
    start_blink = 1'b0;
    start_on    = on_q;
    start_off   = off_q;
    blink_end   = 1'b0;

    if (grant) begin
      for (int i = 0; i < NREQ; i++) ack_d[i] = (req_idx == OWN_W'(i));
      owner_d     = req_idx;
      on_d        = g_on;
      off_d       = g_off;
      rep_d       = g_rep;
      blink_d     = '0;
      start_blink = 1'b1;
      start_on    = g_on;
      start_off   = g_off;
    end else begin
      case (state_q)
        ST_ON: begin
          if (tick && rem_q == CNT_W'(1)) begin
            if (off_q != '0) begin
              state_d = ST_OFF;
              rem_d   = off_q;
            end else begin
              blink_end = 1'b1;
            end
          end else if (tick) begin
            rem_d = rem_q - CNT_W'(1);
          end
        end
        ST_OFF: begin
          // rem_q == 0 here only for an all-zero blink, which takes exactly one cycle.
          if (rem_q == '0 || (tick && rem_q == CNT_W'(1))) blink_end = 1'b1;
          else if (tick)                                   rem_d = rem_q - CNT_W'(1);
        end
        default: ;
      endcase
    end

    if (blink_end) begin
      if (blink_q == rep_eff - REP_W'(1)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        rem_d   = '0;
        blink_d = '0;
      end else begin
        blink_d     = blink_q + REP_W'(1);
        start_blink = 1'b1;
      end
    end

    if (start_blink) begin
      if (start_on != '0) begin
        state_d = ST_ON;
        rem_d   = start_on;
      end else if (start_off != '0) begin
        state_d = ST_OFF;
        rem_d   = start_off;
      end else begin
        state_d = ST_OFF;
        rem_d   = '0;
      end
    end

    led_d  = (state_d == ST_ON);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ack_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      led_q   <= 1'b0;
      armed_q <= 1'b0;
      owner_q <= '0;
      on_q    <= '0;
      off_q   <= '0;
      rep_q   <= '0;
      rem_q   <= '0;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
      armed_q <= armed_d;
      owner_q <= owner_d;
      on_q    <= on_d;
      off_q   <= off_d;
      rep_q   <= rep_d;
      rem_q   <= rem_d;
      blink_q <= blink_d;
    end
  end

  assign ack   = ack_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign owner = owner_q;
  assign LED   = led_q;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed bench for led_blink_scheduler at TICK_DIV=4, NREQ=3; traces are 32-cycle bit vectors.
module tb_led_blink_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [23:0] on_ticks, off_ticks;
  logic [11:0] rep;
  logic [2:0]  ack;
  logic        busy, done, LED;
  logic [1:0]  owner;

  int checks   = 0;
  int failures = 0;

  logic [31:0] led_v, busy_v, done_v, ack0_v, ack1_v, ack2_v;
  logic [1:0]  owner_at [32];

  led_blink_scheduler #(.TICK_DIV(4), .NREQ(3), .CNT_W(8), .REP_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .on_ticks (on_ticks),
    .off_ticks(off_ticks),
    .rep      (rep),
    .ack      (ack),
    .busy     (busy),
    .done     (done),
    .owner    (owner),
    .LED      (LED)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [7:0] on_v, input logic [7:0] off_v,
                        input logic [3:0] rep_v);
    on_ticks[ch*8 +: 8]  = on_v;
    off_ticks[ch*8 +: 8] = off_v;
    rep[ch*4 +: 4]       = rep_v;
  endtask

  // Call right after driving req at a negedge (cycle 0); records cycles 1..31.
  // Requesters drop req on their ack; inj_mask is raised at the end of cycle inj_cycle.
  task automatic capture(input logic [2:0] inj_mask, input int inj_cycle);
    led_v = '0; busy_v = '0; done_v = '0; ack0_v = '0; ack1_v = '0; ack2_v = '0;
    for (int c = 1; c < 32; c++) begin
      @(negedge clk);
      led_v[c]    = LED;
      busy_v[c]   = busy;
      done_v[c]   = done;
      ack0_v[c]   = ack[0];
      ack1_v[c]   = ack[1];
      ack2_v[c]   = ack[2];
      owner_at[c] = owner;
      req = req & ~ack;
      if (c == inj_cycle) req = req | inj_mask;
    end
  endtask

  initial begin
    int waited;
    bit seen_done;

    rst_n = 1'b0; req = '0; on_ticks = '0; off_ticks = '0; rep = '0;
    repeat (3) @(negedge clk);
    check("rst_led",   32'(LED),   32'd0);
    check("rst_ack",   32'(ack),   32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single requester: on=2 off=1 rep=2 -> 8 on, 4 off, 8 on, 4 off.
    set_ch(1, 8'd2, 8'd1, 4'd2);
    req = 3'b010;
    capture(3'b000, 0);
    check("a_ack1", ack1_v, 32'h0000_0002);
    check("a_ack0", ack0_v | ack2_v, 32'h0);
    check("a_led",  led_v,  32'h001F_E1FE);
    check("a_busy", busy_v, 32'h01FF_FFFE);
    check("a_done", done_v, 32'h0200_0000);
    check("a_owner", 32'(owner_at[1]), 32'd1);

    // Two pending: index 1 first, index 2 granted after one IDLE cycle.
    set_ch(1, 8'd1, 8'd1, 4'd1);
    set_ch(2, 8'd1, 8'd0, 4'd1);
    @(negedge clk);
    req = 3'b110;
    capture(3'b000, 0);
    check("b_ack1",   ack1_v, 32'h0000_0002);
    check("b_ack2",   ack2_v, 32'h0000_0400);
    check("b_led",    led_v,  32'h0000_3C1E);
    check("b_done",   done_v, 32'h0000_4200);
    check("b_busy",   busy_v, 32'h0000_3DFE);
    check("b_owner1", 32'(owner_at[1]),  32'd1);
    check("b_owner2", 32'(owner_at[10]), 32'd2);
    check("b_owner_hold", 32'(owner_at[20]), 32'd2);

    // All-zero pattern: ack then done one cycle later, LED never lit.
    set_ch(0, 8'd0, 8'd0, 4'd0);
    @(negedge clk);
    req = 3'b001;
    capture(3'b000, 0);
    check("c_ack0", ack0_v, 32'h0000_0002);
    check("c_done", done_v, 32'h0000_0004);
    check("c_busy", busy_v, 32'h0000_0002);
    check("c_led",  led_v,  32'h0);

    // All-zero with rep=3: three one-cycle blinks.
    set_ch(0, 8'd0, 8'd0, 4'd3);
    @(negedge clk);
    req = 3'b001;
    capture(3'b000, 0);
    check("c3_done", done_v, 32'h0000_0010);
    check("c3_busy", busy_v, 32'h0000_000E);

    // Reset mid-ON with req held: abort at once, re-grant 2 edges after release.
    set_ch(0, 8'd3, 8'd1, 4'd1);
    @(negedge clk);
    req = 3'b001;
    @(negedge clk);
    check("d_ack", 32'(ack), 32'd1);
    @(negedge clk);
    check("d_led_on", 32'(LED), 32'd1);
    rst_n = 1'b0;
    #1;
    check("d_rst_led",  32'(LED),  32'd0);
    check("d_rst_busy", 32'(busy), 32'd0);
    check("d_rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("d_no_grant_1edge", 32'(ack), 32'd0);
    @(negedge clk);
    check("d_regrant",    32'(ack),  32'd1);
    check("d_regrant_busy", 32'(busy), 32'd1);
    req = 3'b000;
    seen_done = 1'b0;
    waited = 0;
    while (!seen_done && waited < 60) begin
      @(negedge clk);
      waited++;
      if (done) seen_done = 1'b1;
    end
    check("d_done_after_regrant", 32'(seen_done), 32'd1);
    check("d_done_cycle", 32'(waited), 32'd16);

    // Owner 2 running, req[0] rises at cycle 3.
    set_ch(2, 8'd2, 8'd2, 4'd1);
    set_ch(0, 8'd1, 8'd1, 4'd1);
    repeat (2) @(negedge clk);
    req = 3'b100;
    capture(3'b001, 3);
    check("e_ack2", ack2_v, 32'h0000_0002);
`ifdef LED_BLINK_PREEMPT_EN
    check("e_ack0", ack0_v, 32'h0000_0010);
    check("e_led",  led_v,  32'h0000_00FE);
    check("e_done", done_v, 32'h0000_1000);
    check("e_busy", busy_v, 32'h0000_0FFE);
`else
    check("e_ack0", ack0_v, 32'h0004_0000);
    check("e_led",  led_v,  32'h003C_01FE);
    check("e_done", done_v, 32'h0402_0000);
    check("e_busy", busy_v, 32'h03FD_FFFE);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
